sk6805_rx: RTL and testbench

Single-wire SK6805 line decoder: the receive end of the LED serial protocol the `Driver_SK6805` transmitter produces. It samples a one-wire GRB stream, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit pixel words. It also detects the latch (reset) low period and flags malformed pulses. It sits in loopback/self-check paths beside the RGB driver, or on a pin that listens to an external LED chain.

---
 rtl/sk6805_rx_if.sv | 21 ++
 rtl/sk6805_rx.sv | 181 ++++++++++++++++++
 tb/tb_sk6805_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sk6805_rx_if.sv
// Pixel/event bundle produced by the SK6805 line decoder.
// The decoder drives it through the master modport; consumers take the slave view.
interface sk6805_rx_if #(
    parameter int IDX_W = 8
);
    logic [23:0]      o_rgb;
    logic             o_valid;
    logic [IDX_W-1:0] o_pix_idx;
    logic             o_latch;
    logic [IDX_W-1:0] o_pix_count;
    logic             o_err;
    logic [15:0]      o_err_cnt;

    modport master (
        output o_rgb, o_valid, o_pix_idx, o_latch, o_pix_count, o_err, o_err_cnt
    );

    modport slave (
        input o_rgb, o_valid, o_pix_idx, o_latch, o_pix_count, o_err, o_err_cnt
    );
endinterface

// File: rtl/sk6805_rx.sv
// sk6805_rx: single-wire SK6805 (GRB, MSB first) line decoder.
// Classifies each high pulse by length into a 0/1 bit, assembles 24-bit
// words (re-ordered to {R,G,B}), detects latch low periods and flags
// malformed pulses.
// Optional feature: define SK6805_RX_ERRCNT_EN to get a saturating 16-bit
// error counter on o_err_cnt; otherwise o_err_cnt is tied to 0.
module sk6805_rx #(
    parameter int BIT_THRESH   = 5,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 12,
    parameter int RESET_CYCLES = 800,
    parameter int IDX_W        = 8
) (
    input  logic        clk_10MHz,
    input  logic        i_rst,
    input  logic        i_din,
    sk6805_rx_if.master px
);
    localparam int LCNT_W = $clog2(RESET_CYCLES + 1);
    localparam int HCNT_W = $clog2(MAX_HIGH + 2);

    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(RESET_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(RESET_CYCLES - 1);
    localparam logic [HCNT_W-1:0] H_MAX     = HCNT_W'(MAX_HIGH);
    localparam logic [HCNT_W-1:0] H_MIN     = HCNT_W'(MIN_HIGH);
    localparam logic [HCNT_W-1:0] H_THRESH  = HCNT_W'(BIT_THRESH);
    localparam logic [IDX_W-1:0]  WORD_MAX  = '1;

    typedef enum logic [1:0] {
        SYNC,
        LOW,
        HIGH
    } state_t;

    state_t            state;
    logic [1:0]        sync_ff;
    logic              din_s;
    logic [LCNT_W-1:0] lcnt;
    logic [HCNT_W-1:0] hcnt;
    logic [4:0]        bit_cnt;
    logic [23:0]       sh;
    logic [IDX_W-1:0]  word_cnt;

    logic [23:0]       rgb_q;
    logic              valid_q;
    logic [IDX_W-1:0]  pix_idx_q;
    logic              latch_q;
    logic [IDX_W-1:0]  pix_count_q;
    logic              err_q;

    logic              new_bit;
    logic [23:0]       sh_next;

    // The bit value is decided from the pulse length at the falling edge.
    assign new_bit = (hcnt >= H_THRESH);
    assign sh_next = {sh[22:0], new_bit};
    assign din_s   = sync_ff[1];

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge clk_10MHz) begin
        if (!i_rst) sync_ff <= 2'b00;
        else        sync_ff <= {sync_ff[0], i_din};
    end

    // Decoder FSM: pulse measurement, bit/word assembly, latch and error detection.
    always_ff @(posedge clk_10MHz) begin
        if (!i_rst) begin
            state       <= SYNC;
            lcnt        <= '0;
            hcnt        <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            word_cnt    <= '0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            pix_idx_q   <= '0;
            latch_q     <= 1'b0;
            pix_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                // Ignore the line until one full latch-length low has been seen.
                SYNC: begin
                    if (din_s) begin
                        lcnt <= '0;
                    end else if (lcnt == LCNT_LAST) begin
                        lcnt  <= LCNT_MAX;
                        state <= LOW;
                    end else begin
                        lcnt <= lcnt + LCNT_W'(1);
                    end
                end
                LOW: begin
                    if (din_s) begin
                        hcnt  <= HCNT_W'(1);
                        state <= HIGH;
                    end else if (lcnt != LCNT_MAX) begin
                        lcnt <= lcnt + LCNT_W'(1);
                        // One-shot: lcnt saturates, so this fires once per low period.
                        if (lcnt == LCNT_LAST) begin
                            // A latch closes a frame that saw any activity, so a
                            // frame holding only a partial word still reports a
                            // latch (with count 0) alongside the error.
                            if (word_cnt != '0 || bit_cnt != '0) begin
                                latch_q     <= 1'b1;
                                pix_count_q <= word_cnt;
                                word_cnt    <= '0;
                                pix_idx_q   <= '0;
                            end
                            if (bit_cnt != '0) begin
                                err_q   <= 1'b1;
                                bit_cnt <= '0;
                            end
                        end
                    end
                end
                HIGH: begin
                    if (din_s) begin
                        // Pulse already too long: abandon and resynchronise.
                        if (hcnt == H_MAX) begin
                            err_q   <= 1'b1;
                            bit_cnt <= '0;
                            lcnt    <= '0;
                            state   <= SYNC;
                        end else begin
                            hcnt <= hcnt + HCNT_W'(1);
                        end
                    end else if (hcnt < H_MIN) begin
                        err_q   <= 1'b1;
                        bit_cnt <= '0;
                        lcnt    <= '0;
                        state   <= SYNC;
                    end else begin
                        sh    <= sh_next;
                        lcnt  <= LCNT_W'(1);
                        state <= LOW;
                        if (bit_cnt == 5'd23) begin
                            // Wire order is G,R,B; present as R,G,B.
                            rgb_q     <= {sh_next[15:8], sh_next[23:16], sh_next[7:0]};
                            valid_q   <= 1'b1;
                            pix_idx_q <= word_cnt;
                            bit_cnt   <= '0;
                            if (word_cnt != WORD_MAX) word_cnt <= word_cnt + IDX_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= SYNC;
                    lcnt  <= '0;
                end
            endcase
        end
    end

    assign px.o_rgb       = rgb_q;
    assign px.o_valid     = valid_q;
    assign px.o_pix_idx   = pix_idx_q;
    assign px.o_latch     = latch_q;
    assign px.o_pix_count = pix_count_q;
    assign px.o_err       = err_q;

`ifdef SK6805_RX_ERRCNT_EN
    logic [15:0] err_cnt;

    // Saturating count of error pulses; cleared only by reset.
    always_ff @(posedge clk_10MHz) begin
        if (!i_rst)                        err_cnt <= '0;
        else if (err_q && err_cnt != '1)   err_cnt <= err_cnt + 16'd1;
    end

    assign px.o_err_cnt = err_cnt;
`else
    assign px.o_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sk6805_rx.sv
// Bench for sk6805_rx: drives GRB bit streams on the line and checks decoded
// words, latches and errors against a scoreboard of expected events.
module tb_sk6805_rx;
    localparam int IDX_W = 8;
    localparam int LATCH_LOW = 850;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;

    sk6805_rx_if #(.IDX_W(IDX_W)) px ();

    sk6805_rx #(
        .BIT_THRESH(5), .MIN_HIGH(2), .MAX_HIGH(12),
        .RESET_CYCLES(800), .IDX_W(IDX_W)
    ) dut (
        .clk_10MHz(clk),
        .i_rst    (rst_n),
        .i_din    (din),
        .px       (px)
    );

    always #50 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0]      rgb;
        logic [IDX_W-1:0] idx;
    } word_t;

    word_t vq[$];
    int    lq[$];
    int    err_seen  = 0;
    int    latch_err = 0;

    // Scoreboard side: compare every output event against the queued expectation.
    always @(negedge clk) begin
        word_t w;
        int    pc;
        if (rst_n) begin
            if (px.o_valid) begin
                if (vq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else begin
                    w = vq.pop_front();
                    chk("rgb", 32'(px.o_rgb), 32'(w.rgb));
                    chk("pix_idx", 32'(px.o_pix_idx), 32'(w.idx));
                end
            end
            if (px.o_latch) begin
                if (lq.size() == 0) chk("unexpected_latch", 32'd1, 32'd0);
                else begin
                    pc = lq.pop_front();
                    chk("pix_count", 32'(px.o_pix_count), 32'(pc));
                end
            end
            if (px.o_err) err_seen++;
            if (px.o_err && px.o_latch) latch_err++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        din = 1'b1;
        tick(b ? 6 : 3);
        din = 1'b0;
        tick(b ? 6 : 9);
    endtask

    task automatic send_bits(input logic [23:0] grb, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(grb[i]);
    endtask

    task automatic push_exp(input logic [23:0] rgb, input int idx);
        word_t w;
        w.rgb = rgb;
        w.idx = IDX_W'(idx);
        vq.push_back(w);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rgb"},       32'(px.o_rgb), 32'd0);
        chk({pfx, "_valid"},     32'(px.o_valid), 32'd0);
        chk({pfx, "_pix_idx"},   32'(px.o_pix_idx), 32'd0);
        chk({pfx, "_latch"},     32'(px.o_latch), 32'd0);
        chk({pfx, "_pix_count"}, 32'(px.o_pix_count), 32'd0);
        chk({pfx, "_err"},       32'(px.o_err), 32'd0);
        chk({pfx, "_err_cnt"},   32'(px.o_err_cnt), 32'd0);
    endtask

    initial begin
        int e0, le0, first;

        // Reset state
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(LATCH_LOW);

        // Single word, then latch
        push_exp(24'hFF0000, 0);
        send_bits(24'h00FF00, 24);
        lq.push_back(1);
        tick(LATCH_LOW);
        chk("t1_drained", 32'(vq.size() + lq.size()), 32'd0);

        // Three back-to-back words
        push_exp(24'h341256, 0);
        push_exp(24'hCDABEF, 1);
        push_exp(24'h000001, 2);
        send_bits(24'h123456, 24);
        send_bits(24'hABCDEF, 24);
        send_bits(24'h000001, 24);
        lq.push_back(3);
        tick(LATCH_LOW);
        chk("t2_drained", 32'(vq.size() + lq.size()), 32'd0);

        // Over-long high pulse: error when hcnt would pass MAX_HIGH
        e0 = err_seen;
        first = 0;
        din = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (px.o_err && first == 0) first = c;
        end
        din = 1'b0;
        chk("long_high_err_cycle", 32'(first), 32'd15);
        tick(LATCH_LOW);
        chk("long_high_err_count", 32'(err_seen - e0), 32'd1);
`ifdef SK6805_RX_ERRCNT_EN
        chk("long_high_err_cnt", 32'(px.o_err_cnt), 32'd1);
`endif

        // One-clock glitch mid-word, resync, then a good word
        e0 = err_seen;
        send_bits(24'hA50000, 5);
        din = 1'b1;
        tick(1);
        din = 1'b0;
        tick(LATCH_LOW);
        chk("glitch_err_count", 32'(err_seen - e0), 32'd1);
        push_exp(24'hC3A53C, 0);
        send_bits(24'hA5C33C, 24);
        lq.push_back(1);
        tick(LATCH_LOW);
        chk("t4_drained", 32'(vq.size() + lq.size()), 32'd0);

        // Partial word then latch: latch and error together, count 0
        e0 = err_seen;
        le0 = latch_err;
        send_bits(24'hF0F0F0, 10);
        lq.push_back(0);
        tick(LATCH_LOW);
        chk("partial_err_count", 32'(err_seen - e0), 32'd1);
        chk("partial_latch_with_err", 32'(latch_err - le0), 32'd1);
`ifdef SK6805_RX_ERRCNT_EN
        chk("partial_err_cnt", 32'(px.o_err_cnt), 32'd3);
`endif

        // Reset mid-word: everything clears, next word ignored until a latch period
        e0 = err_seen;
        send_bits(24'h5A5A5A, 12);
        rst_n = 1'b0;
        tick(1);
        chk_all_zero("midword_reset");
        rst_n = 1'b1;
        send_bits(24'h123456, 24);
        tick(LATCH_LOW);
        chk("post_reset_ignored", 32'(vq.size() + lq.size()), 32'd0);
        push_exp(24'hFF0000, 0);
        send_bits(24'h00FF00, 24);
        lq.push_back(1);
        tick(LATCH_LOW);
        chk("post_reset_err_count", 32'(err_seen - e0), 32'd0);

        chk("final_valid_q_empty", 32'(vq.size()), 32'd0);
        chk("final_latch_q_empty", 32'(lq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
